data_mem_mp: RTL

//  Parametrised per-PE data memory: one write port shared by sequential load and
//  ALU write-back, NUM_RD synchronous read ports addressed from instruction fields.

---
 rtl/data_mem_mp_if.sv | 39 +++
 rtl/data_mem_mp.sv | 129 ++++++++++++
 2 files changed

// File: rtl/data_mem_mp_if.sv
// data_mem_mp_if: instruction, read, load and write-back bundle
// for the per-PE data memory.
interface data_mem_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2,
  parameter int INST_W = 32
);
  logic                     inst_v;
  logic [INST_W-1:0]        inst;
  logic                     rden;
  logic                     ld_en;
  logic                     ld_clr;
  logic [DATA_W-1:0]        ld_data;
  logic                     wb_en;
  logic [DATA_W-1:0]        wb_data;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     rvalid;
  logic [ADDR_W-1:0]        ld_ptr;
  logic                     ld_full;
  logic                     ld_drop;
  logic                     wb_err;

  modport master (
    output inst_v, inst, rden,
    output ld_en, ld_clr, ld_data,
    output wb_en, wb_data,
    input  rdata, rvalid, ld_ptr,
    input  ld_full, ld_drop, wb_err
  );

  modport slave (
    input  inst_v, inst, rden,
    input  ld_en, ld_clr, ld_data,
    input  wb_en, wb_data,
    output rdata, rvalid, ld_ptr,
    output ld_full, ld_drop, wb_err
  );
endinterface

// File: rtl/data_mem_mp.sv
// data_mem_mp: per-PE data memory, shared load/write-back port, NUM_RD read ports.
// Define DM_BYPASS_EN for write-first forwarding on the read ports.
module data_mem_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2,
  parameter int INST_W = 32,
  parameter int WB_LAT = 5
) (
  input  logic clk,
  input  logic rst,
  data_mem_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0] src_q, src_d;
  logic [WB_LAT-1:0][ADDR_W-1:0] dst_q, dst_d;
  logic [WB_LAT-1:0]             vld_q, vld_d;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                          rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]             ld_ptr_q, ld_ptr_d;
  logic                          ld_full_q, ld_full_d;
  logic                          ld_drop_q, ld_drop_d;
  logic                          wb_err_q, wb_err_d;

  logic              wb_hit;
  logic              ld_go;
  logic [ADDR_W-1:0] ld_addr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic unused_inst;
  assign unused_inst = ^bus.inst;

  always_comb begin
    wb_hit  = bus.wb_en & vld_q[WB_LAT-1];
    ld_go   = bus.ld_en & ~wb_hit;
    ld_addr = bus.ld_clr ? '0 : ld_ptr_q;
    we      = wb_hit | ld_go;
    waddr   = wb_hit ? dst_q[WB_LAT-1] : ld_addr;
    wdata   = wb_hit ? bus.wb_data : bus.ld_data;
  end

  always_comb begin
    ld_ptr_d  = ld_ptr_q;
    ld_full_d = ld_full_q;
    ld_drop_d = bus.ld_en & wb_hit;
    wb_err_d  = bus.wb_en & ~vld_q[WB_LAT-1];
    if (bus.ld_clr) begin
      ld_ptr_d  = '0;
      ld_full_d = 1'b0;
    end
    if (ld_go) begin
      ld_ptr_d = ld_addr + 1'b1;
      if (ld_addr == PTR_MAX) ld_full_d = 1'b1;
    end
  end

  // stage i holds the dst decoded i+1 edges ago; the last stage is the tap
  always_comb begin
    vld_d    = vld_q;
    dst_d    = dst_q;
    vld_d[0] = bus.inst_v;
    dst_d[0] = bus.inst[ADDR_W-1:0];
    for (int i = WB_LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      dst_d[i] = dst_q[i-1];
    end
  end

  always_comb begin
    src_d    = src_q;
    rdata_d  = rdata_q;
    rvalid_d = bus.rden;
    if (bus.inst_v) begin
      for (int k = 0; k < NUM_RD; k++) begin
        src_d[k] = bus.inst[8*(k+1) +: ADDR_W];
      end
    end
    if (bus.rden) begin
      for (int k = 0; k < NUM_RD; k++) begin
        rdata_d[k] = mem[src_q[k]];
`ifdef DM_BYPASS_EN
        if (we && (waddr == src_q[k])) rdata_d[k] = wdata;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      vld_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ld_ptr_q  <= '0;
      ld_full_q <= 1'b0;
      ld_drop_q <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      vld_q     <= vld_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ld_ptr_q  <= ld_ptr_d;
      ld_full_q <= ld_full_d;
      ld_drop_q <= ld_drop_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.ld_ptr  = ld_ptr_q;
  assign bus.ld_full = ld_full_q;
  assign bus.ld_drop = ld_drop_q;
  assign bus.wb_err  = wb_err_q;

endmodule
